// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the derivation of the iteration counter width.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Control for the sequential multiplier: IDLE/CALC/DONE state machine plus the
// iteration counter. Status outputs are registered alongside the state so they
// never depend combinationally on the start request.
//
// Handshake: a start request is accepted on a rising edge where idle=1 and
// st=1; requests in any other cycle are dropped, not queued. done pulses for
// exactly one cycle, WIDTH+1 cycles after acceptance.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic st,
  output logic load,
  output logic calc,
  output logic last,
  output logic idle,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Strobes for the datapath: capture operands, run one iteration, final one.
  always_comb begin
    load = (state == S_IDLE) && st;
    calc = (state == S_CALC);
    last = (state == S_CALC) && (cnt == LAST_CNT);
  end

  // State machine, iteration counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idle  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (st) begin
            state <= S_CALC;
            cnt   <= '0;
            idle  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          idle  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier for the CPU multiply unit. One multiplier
// bit is consumed per cycle; signed mode subtracts the multiplicand on the
// final (MSB) iteration to apply the negative two's-complement weight.
// The upper accumulator carries one guard bit so it never overflows.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               St,
  input  logic               Sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Idle,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic load, calc, last;

  logic [WIDTH-1:0] mcand;
  logic             mode;
  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] lower;

  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   addend;
  logic [WIDTH+1:0] sum;
  logic             shift_in;
  logic [WIDTH:0]   upper_n;
  logic [WIDTH-1:0] lower_n;

  seq_mul_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk  (Clk),
    .rst  (Rst),
    .st   (St),
    .load (load),
    .calc (calc),
    .last (last),
    .idle (Idle),
    .busy (Busy),
    .done (Done)
  );

  // One iteration: add/subtract the extended multiplicand, then shift right.
  always_comb begin
    ext    = mode ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
    addend = lower[0] ? ext : '0;
    if (mode && last)
      sum = {upper[WIDTH], upper} - {addend[WIDTH], addend};
    else if (mode)
      sum = {upper[WIDTH], upper} + {addend[WIDTH], addend};
    else
      sum = {1'b0, upper} + {1'b0, addend};
    // Signed: the guard bit is already the true sign. Unsigned: the carry.
    shift_in = mode ? sum[WIDTH] : sum[WIDTH+1];
    upper_n  = {shift_in, sum[WIDTH:1]};
    lower_n  = {sum[0], lower[WIDTH-1:1]};
  end

  // Operand capture, accumulator iteration and product hold register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mcand   <= '0;
      mode    <= 1'b0;
      upper   <= '0;
      lower   <= '0;
      Product <= '0;
    end else begin
      if (load) begin
        mcand <= A;
        mode  <= Sgn;
        upper <= '0;
        lower <= B;
      end else if (calc) begin
        upper <= upper_n;
        lower <= lower_n;
      end
      // Product becomes visible in the DONE cycle itself.
      if (last)
        Product <= {upper_n[WIDTH-1:0], lower_n};
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a WIDTH=8 and a WIDTH=32 instance share clock and
// reset. A phase-count model predicts status flags and the held product every
// cycle; directed cases pin the model with hand-computed literals.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        idle8, busy8, done8;
  logic [15:0] prod8;

  logic        st32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        idle32, busy32, done32;
  logic [63:0] prod32;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst), .St(st8), .Sgn(sgn8), .A(a8), .B(b8),
    .Idle(idle8), .Busy(busy8), .Done(done8), .Product(prod8)
  );

  seq_multiplier #(.WIDTH(32)) dut32 (
    .Clk(clk), .Rst(rst), .St(st32), .Sgn(sgn32), .A(a32), .B(b32),
    .Idle(idle32), .Busy(busy32), .Done(done32), .Product(prod32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1..W busy, W+1 done.
  int ph8 = 0, ph32 = 0;
  logic [15:0] mp8 = '0, pend8 = '0;
  logic [63:0] mp32 = '0, pend32 = '0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] ref_mul(input logic s, input logic [63:0] x,
                                          input logic [63:0] y, input int w);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy, r;
    ux = x & ((64'd1 << w) - 1);
    uy = y & ((64'd1 << w) - 1);
    sx = (s && ux[w-1]) ? $signed(ux - (64'd1 << w)) : $signed(ux);
    sy = (s && uy[w-1]) ? $signed(uy - (64'd1 << w)) : $signed(uy);
    r  = s ? 64'(sx * sy) : ux * uy;
    if (w < 32) r = r & ((64'd1 << (2 * w)) - 1);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph8 = 0; mp8 = '0;
    end else if (ph8 == 0) begin
      if (st8) begin ph8 = 1; pend8 = 16'(ref_mul(sgn8, 64'(a8), 64'(b8), 8)); end
    end else if (ph8 == 8) begin
      ph8 = 9; mp8 = pend8;
    end else if (ph8 == 9) ph8 = 0;
    else ph8++;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph32 = 0; mp32 = '0;
    end else if (ph32 == 0) begin
      if (st32) begin ph32 = 1; pend32 = ref_mul(sgn32, 64'(a32), 64'(b32), 32); end
    end else if (ph32 == 32) begin
      ph32 = 33; mp32 = pend32;
    end else if (ph32 == 33) ph32 = 0;
    else ph32++;
  end

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("idle8", 64'(idle8), 64'(ph8 == 0));
      chk("busy8", 64'(busy8), 64'(ph8 >= 1 && ph8 <= 8));
      chk("done8", 64'(done8), 64'(ph8 == 9));
      chk("prod8", 64'(prod8), 64'(mp8));
      chk("onehot8", 64'($countones({idle8, busy8, done8})), 64'd1);
      chk("idle32", 64'(idle32), 64'(ph32 == 0));
      chk("busy32", 64'(busy32), 64'(ph32 >= 1 && ph32 <= 32));
      chk("done32", 64'(done32), 64'(ph32 == 33));
      chk("prod32", prod32, mp32);
      if (done32) begin
        if (exp_q.size() == 0) chk("q32_empty", 64'd1, 64'd0);
        else chk("sb32", prod32, exp_q.pop_front());
      end
    end
  end

  // driver: one 8-bit operation, entered and left on a falling edge
  task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] expv, input string nm);
    int n;
    st8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    n = 1;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, 64'(n), 64'd9);
    chk(nm, 64'(prod8), 64'(expv));
    @(negedge clk);
  endtask

  // driver: one 32-bit operation with St-to-Idle latency check
  task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y);
    int n;
    exp_q.push_back(ref_mul(s, 64'(x), 64'(y), 32));
    st32 = 1'b1; sgn32 = s; a32 = x; b32 = y;
    @(negedge clk);
    st32 = 1'b0; a32 = $urandom; b32 = $urandom;
    n = 1;
    while (!idle32 && n < 60) begin @(negedge clk); n++; end
    chk("lat32", 64'(n), 64'd34);
  endtask

  initial begin
    int nd;
    logic [7:0] rx, ry;
    logic rs;

    repeat (2) @(negedge clk);
    chk("rst_idle", 64'(idle8), 64'd1);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_prod", 64'(prod8), 64'd0);
    chk("rst_prod32", prod32, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed WIDTH=8 cases with literal expectations
    op8(1'b0, 8'd13, 8'd11, 16'd143, "u13x11");
    repeat (3) @(negedge clk);
    chk("hold143", 64'(prod8), 64'd143);
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "umax");
    op8(1'b1, 8'hFD, 8'h05, 16'hFFF1, "sm3x5");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "sminmin");
    op8(1'b1, 8'h7F, 8'h80, 16'hC080, "smaxmin");
    op8(1'b0, 8'h00, 8'hFF, 16'h0000, "uzero");
    op8(1'b1, 8'h00, 8'hFF, 16'h0000, "szero");
    op8(1'b1, 8'hFF, 8'hFF, 16'h0001, "sm1m1");

    // random WIDTH=8
    for (int i = 0; i < 60; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom_range(0, 1));
      op8(rs, rx, ry, 16'(ref_mul(rs, 64'(rx), 64'(ry), 8)), "rand8");
    end

    // St held high, operands changing every cycle
    st8 = 1'b1; sgn8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) begin
        nd++;
        if (nd == 1) chk("held_first", 64'(prod8), 64'd15);
      end
    end
    chk("held_dones", 64'(nd), 64'd3);
    st8 = 1'b0;
    for (int i = 0; i < 20 && !idle8; i++) @(negedge clk);
    chk("held_idle", 64'(idle8), 64'd1);

    // asynchronous reset at iteration 4
    st8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd100;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_idle", 64'(idle8), 64'd1);
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_prod", 64'(prod8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    op8(1'b0, 8'd6, 8'd7, 16'd42, "after_rst");

    // WIDTH=32 boundaries then random pairs
    op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op32(1'b1, 32'h8000_0000, 32'h8000_0000);
    op32(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    op32(1'b0, 32'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 1000; i++)
      op32(1'($urandom_range(0, 1)), $urandom, $urandom);
    repeat (2) @(negedge clk);
    chk("q32_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
